// File: rtl/shiftreg_serial_ctrl.sv
// Full-duplex serial transceiver sequencer driving an external PLOAD/RIGHT/LEFT/HOLD
// shift register: parallel-load a word, shift it out while shifting sdi in, return it.
module shiftreg_serial_ctrl #(
    parameter int unsigned width  = 8,
    parameter int unsigned CLKDIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             dir,
    output logic [width-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    input  logic             sdi,
    output logic             sdo,
    output logic             sclk,
    output logic             busy,
    output logic [1:0]       sr_mode,
    output logic [width-1:0] sr_pin,
    output logic             sr_sin,
    input  logic [width-1:0] sr_pout
);

    localparam logic [1:0] ModeHold  = 2'b00;
    localparam logic [1:0] ModeRight = 2'b01;
    localparam logic [1:0] ModeLeft  = 2'b10;
    localparam logic [1:0] ModePload = 2'b11;

    localparam int unsigned DivW = $clog2(CLKDIV);
    localparam int unsigned BitW = $clog2(width + 1);

    localparam logic [DivW-1:0] DivHalf   = DivW'(CLKDIV / 2);
    localparam logic [DivW-1:0] DivSample = DivW'(CLKDIV / 2 - 1);
    localparam logic [DivW-1:0] DivLast   = DivW'(CLKDIV - 1);
    localparam logic [BitW-1:0] BitLast   = BitW'(width - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [width-1:0]  word_q, word_d;
    logic              dir_q, dir_d;
    logic [BitW-1:0]   bitcnt_q, bitcnt_d;
    logic [DivW-1:0]   divcnt_q, divcnt_d;
    logic              sample_q, sample_d;
    logic [width-1:0]  rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            word_q     <= '0;
            dir_q      <= 1'b0;
            bitcnt_q   <= '0;
            divcnt_q   <= '0;
            sample_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            dir_q      <= dir_d;
            bitcnt_q   <= bitcnt_d;
            divcnt_q   <= divcnt_d;
            sample_q   <= sample_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        dir_d      = dir_q;
        bitcnt_d   = bitcnt_q;
        divcnt_d   = divcnt_q;
        sample_d   = sample_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        tx_ready   = 1'b0;
        sr_mode    = ModeHold;
        sr_pin     = '0;
        sr_sin     = 1'b0;
        sdo        = 1'b0;
        sclk       = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                // Hold off new words until the previous result has been taken.
                tx_ready = !rx_valid_q;
                if (tx_valid && !rx_valid_q) begin
                    word_d  = tx_data;
                    dir_d   = dir;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                sr_mode  = ModePload;
                sr_pin   = word_q;
                bitcnt_d = '0;
                divcnt_d = '0;
                state_d  = StShift;
            end
            StShift: begin
                sclk = (divcnt_q >= DivHalf);
                sdo  = dir_q ? sr_pout[0] : sr_pout[width-1];
                if (divcnt_q == DivSample) begin
                    sample_d = sdi;
                end
                if (divcnt_q == DivLast) begin
                    divcnt_d = '0;
                    sr_mode  = dir_q ? ModeRight : ModeLeft;
                    sr_sin   = sample_q;
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == BitLast) begin
                        state_d = StDone;
                    end
                end else begin
                    divcnt_d = divcnt_q + 1'b1;
                end
            end
            StDone: begin
                rx_data_d  = sr_pout;
                rx_valid_d = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy     = (state_q != StIdle);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_shiftreg_serial_ctrl.sv
// Scoreboard bench for shiftreg_serial_ctrl: two instances (CLKDIV 2 and 4), each with a
// behavioural shift register; a negedge monitor checks results, pacing and latency.
module tb_shiftreg_serial_ctrl;

    localparam int W = 4;
    localparam logic [1:0] M_HOLD  = 2'b00;
    localparam logic [1:0] M_RIGHT = 2'b01;
    localparam logic [1:0] M_LEFT  = 2'b10;
    localparam logic [1:0] M_PLOAD = 2'b11;

    typedef struct {
        int         inst;
        logic [3:0] data;
    } exp_t;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus-side signals, index 0 = CLKDIV 2 instance, index 1 = CLKDIV 4 instance
    logic [1:0]      rst_n, tx_valid, dir, rx_ready, loop;
    logic [1:0][3:0] tx_data;
    logic [1:0][7:0] pat;
    logic [1:0]      tx_ready, rx_valid, sdo, sclk, busy, sr_sin, sdi;
    logic [1:0][3:0] rx_data, sr_pin, sr_q;
    logic [1:0][1:0] sr_mode;

    // Monitor state
    exp_t       exp_q[$];
    exp_t       e;
    int         n_pload[2], n_left[2], n_right[2], done_cnt[2];
    int         acc_edge[2], last_rise[2];
    bit         have_rise[2];
    logic [3:0] sdo_seq[2];
    logic       rxv_prev[2], sclk_prev[2];

    assign sdi[0] = loop[0] ? sdo[0] : pat[0][n_left[0] + n_right[0]];
    assign sdi[1] = loop[1] ? sdo[1] : pat[1][n_left[1] + n_right[1]];

    shiftreg_serial_ctrl #(.width(W), .CLKDIV(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .dir(dir[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
        .rx_ready(rx_ready[0]), .sdi(sdi[0]), .sdo(sdo[0]), .sclk(sclk[0]), .busy(busy[0]),
        .sr_mode(sr_mode[0]), .sr_pin(sr_pin[0]), .sr_sin(sr_sin[0]), .sr_pout(sr_q[0])
    );

    shiftreg_serial_ctrl #(.width(W), .CLKDIV(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .dir(dir[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
        .rx_ready(rx_ready[1]), .sdi(sdi[1]), .sdo(sdo[1]), .sclk(sclk[1]), .busy(busy[1]),
        .sr_mode(sr_mode[1]), .sr_pin(sr_pin[1]), .sr_sin(sr_sin[1]), .sr_pout(sr_q[1])
    );

    // Behavioural shift registers: LEFT inserts at bit 0, RIGHT at bit W-1
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            case (sr_mode[g])
                M_PLOAD: sr_q[g] <= sr_pin[g];
                M_LEFT:  sr_q[g] <= {sr_q[g][2:0], sr_sin[g]};
                M_RIGHT: sr_q[g] <= {sr_sin[g], sr_q[g][3:1]};
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            n_pload[g] = 0; n_left[g] = 0; n_right[g] = 0; done_cnt[g] = 0;
            acc_edge[g] = 0; last_rise[g] = 0; have_rise[g] = 0; sdo_seq[g] = '0;
            rxv_prev[g] = 1'b0; sclk_prev[g] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                int div;
                div = (g == 0) ? 2 : 4;
                if (rst_n[g] === 1'b1 && tx_valid[g] === 1'b1 && tx_ready[g] === 1'b1) begin
                    acc_edge[g]  = cyc + 1;
                    n_pload[g]   = 0;
                    n_left[g]    = 0;
                    n_right[g]   = 0;
                    sdo_seq[g]   = '0;
                    have_rise[g] = 0;
                end
                if (sclk[g] === 1'b1 && sclk_prev[g] === 1'b0) begin
                    if (have_rise[g]) check("sclk_period", cyc - last_rise[g], div);
                    last_rise[g] = cyc;
                    have_rise[g] = 1;
                end
                if (sclk[g] === 1'b0 && sclk_prev[g] === 1'b1) begin
                    check("sclk_high_time", cyc - last_rise[g], div / 2);
                end
                if (sr_mode[g] === M_PLOAD) n_pload[g]++;
                if (sr_mode[g] === M_LEFT || sr_mode[g] === M_RIGHT) begin
                    if (have_rise[g]) check("shift_after_rise", cyc - last_rise[g], div / 2 - 1);
                    sdo_seq[g] = {sdo_seq[g][2:0], sdo[g]};
                    if (sr_mode[g] === M_LEFT) n_left[g]++;
                    else n_right[g]++;
                end
                if (rx_valid[g] === 1'b1 && rxv_prev[g] === 1'b0) begin
                    check("rx_latency", cyc - acc_edge[g], W * div + 2);
                end
                if (rx_valid[g] === 1'b1 && rx_ready[g] === 1'b1) begin
                    done_cnt[g]++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rx_unexpected: dut %0d gave 0x%0h, expected no result",
                                 g, rx_data[g]);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_inst", g, e.inst);
                        check("rx_data", rx_data[g], e.data);
                    end
                end
                rxv_prev[g]  = rx_valid[g];
                sclk_prev[g] = sclk[g];
            end
        end
    end

    task automatic chk_reset(input int g);
        check("rst_tx_ready", tx_ready[g], 1);
        check("rst_rx_valid", rx_valid[g], 0);
        check("rst_rx_data", rx_data[g], 0);
        check("rst_sclk", sclk[g], 0);
        check("rst_sdo", sdo[g], 0);
        check("rst_busy", busy[g], 0);
        check("rst_sr_mode", sr_mode[g], M_HOLD);
        check("rst_sr_pin", sr_pin[g], 0);
        check("rst_sr_sin", sr_sin[g], 0);
    endtask

    task automatic issue(input int g, input logic [3:0] d, input logic dr);
        tx_data[g]  = d;
        dir[g]      = dr;
        tx_valid[g] = 1'b1;
        for (int i = 0; i < 100 && tx_ready[g] !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        check("accept_ready", tx_ready[g], 1);
        @(posedge clk); #1;
        tx_valid[g] = 1'b0;
    endtask

    task automatic xfer(input int g, input logic [3:0] d, input logic dr,
                        input logic [3:0] exp_rx, input logic [3:0] exp_sdo);
        int start;
        start = done_cnt[g];
        exp_q.push_back('{g, exp_rx});
        issue(g, d, dr);
        for (int i = 0; i < 200 && done_cnt[g] == start; i++) begin
            @(posedge clk); #1;
        end
        check("xfer_done", done_cnt[g] - start, 1);
        check("pload_count", n_pload[g], 1);
        check("shift_count", dr ? n_right[g] : n_left[g], W);
        check("wrong_dir_shifts", dr ? n_left[g] : n_right[g], 0);
        check("sdo_bits", sdo_seq[g], exp_sdo);
    endtask

    initial begin
        rst_n    = 2'b00;
        tx_valid = 2'b00;
        dir      = 2'b00;
        rx_ready = 2'b11;
        loop     = 2'b11;
        tx_data  = '0;
        pat      = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 2'b11;
        chk_reset(0);
        chk_reset(1);

        // MSB-first loopback
        xfer(0, 4'b1010, 1'b0, 4'b1010, 4'b1010);

        // LSB-first with sdi driven 1,0,0,0 per bit period
        loop[0] = 1'b0;
        pat[0]  = 8'b0000_0001;
        xfer(0, 4'b0011, 1'b1, 4'b0001, 4'b1100);
        loop[0] = 1'b1;

        // Backpressure: result held, next word blocked until rx taken
        rx_ready[0] = 1'b0;
        exp_q.push_back('{0, 4'b0101});
        issue(0, 4'b0101, 1'b0);
        for (int i = 0; i < 100 && rx_valid[0] !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        check("bp_rx_valid_rise", rx_valid[0], 1);
        tx_data[0]  = 4'b0110;
        tx_valid[0] = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_rx_valid_hold", rx_valid[0], 1);
            check("bp_rx_data_hold", rx_data[0], 4'b0101);
            check("bp_tx_ready", tx_ready[0], 0);
            check("bp_no_pload", n_pload[0], 1);
        end
        rx_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("bp_rx_cleared", rx_valid[0], 0);
        check("bp_tx_ready_after", tx_ready[0], 1);
        @(posedge clk); #1;
        tx_valid[0] = 1'b0;
        check("bp_pload_next", sr_mode[0], M_PLOAD);
        exp_q.push_back('{0, 4'b0110});
        begin
            int start;
            start = done_cnt[0];
            for (int i = 0; i < 100 && done_cnt[0] == start; i++) begin
                @(posedge clk); #1;
            end
            check("bp_second_done", done_cnt[0] - start, 1);
        end

        // Reset after 2 shifts: transfer abandoned, no result
        issue(0, 4'b1001, 1'b0);
        for (int i = 0; i < 100 && n_left[0] < 2; i++) begin
            @(posedge clk); #1;
        end
        check("mid_reset_shifts", n_left[0], 2);
        rst_n[0] = 1'b0;
        @(posedge clk); #1;
        check("mid_reset_busy", busy[0], 0);
        check("mid_reset_sclk", sclk[0], 0);
        check("mid_reset_sdo", sdo[0], 0);
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        chk_reset(0);
        repeat (12) @(posedge clk);
        #1;
        check("mid_reset_no_rx", rx_valid[0], 0);
        xfer(0, 4'b1100, 1'b0, 4'b1100, 4'b1100);

        // CLKDIV=4 instance, both directions in loopback
        xfer(1, 4'b1011, 1'b0, 4'b1011, 4'b1011);
        xfer(1, 4'b0110, 1'b1, 4'b0110, 4'b0110);

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
